uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of uart_rx. It captures each single-cycle o_valid pulse from uart_rx (o_dout data plus o_error bits) into a synchronous FIFO. It presents entries to the host on a first-word-fall-through ready/valid interface. It also provides fill status, a sticky overrun flag, and a 16550-style character timeout, so the host can drain partial bursts without polling.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 84 ++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART type and sizing definitions for the RX/TX buffering blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_ERR_WIDTH  = 2;

  typedef struct packed {
    logic [UART_ERR_WIDTH-1:0]  err;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_rx_entry_t;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with an explicit occupancy count.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_ERR_WIDTH + UART_DATA_WIDTH,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             push,
  output logic             pop,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: FWFT FIFO plus overrun, almost-full and character timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned ERR_WIDTH    = UART_ERR_WIDTH,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned TIMEOUT_CLKS = 8680,
  localparam int unsigned CW = count_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [ERR_WIDTH-1:0]  i_rx_error,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [ERR_WIDTH-1:0]  o_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun,
  output logic                  o_timeout
);

  localparam int unsigned EW = ERR_WIDTH + DATA_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_check
    $error("uart_rx_fifo: AFULL_LEVEL must lie in 1..DEPTH");
  end

  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;
  logic [TW-1:0] idle;

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_data  ({i_rx_error, i_rx_data}),
    .wr_en    (i_rx_valid),
    .rd_data  (head),
    .rd_valid (o_valid),
    .rd_ready (i_ready),
    .count    (o_count),
    .empty    (o_empty),
    .full     (o_full),
    .push     (push),
    .pop      (pop),
    .drop     (drop)
  );

  assign o_dout    = head[DATA_WIDTH-1:0];
  assign o_err     = head[EW-1:DATA_WIDTH];
  assign o_afull   = (o_count >= CW'(AFULL_LEVEL));
  assign o_timeout = (idle == TW'(TIMEOUT_CLKS)) && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overrun <= 1'b0;
      idle      <= '0;
    end else begin
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)               o_overrun <= 1'b1;
      else if (i_clr_overrun) o_overrun <= 1'b0;

      if (push || pop || o_empty)            idle <= '0;
      else if (idle != TW'(TIMEOUT_CLKS))    idle <= idle + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, hand sequences and a random run against a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;
  localparam int unsigned TO    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic [1:0] rx_err = '0;
  logic       rx_valid = 1'b0;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] dout;
  logic [1:0] err;
  logic       valid;
  logic [4:0] count;
  logic       empty, full, afull, overrun, timeout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  uart_rx_fifo #(
    .DATA_WIDTH   (8),
    .ERR_WIDTH    (2),
    .DEPTH        (DEPTH),
    .AFULL_LEVEL  (AFULL),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_data     (rx_data),
    .i_rx_error    (rx_err),
    .i_rx_valid    (rx_valid),
    .o_dout        (dout),
    .o_err         (err),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_count       (count),
    .o_empty       (empty),
    .o_full        (full),
    .o_afull       (afull),
    .o_overrun     (overrun),
    .i_clr_overrun (clr),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {err,data} plus a time-of-last-activity stamp.
  logic [9:0]  q[$];
  bit          m_ovr;
  int unsigned cyc;
  int unsigned last_act;

  function automatic void model_step(input logic r, v, input logic [7:0] d,
                                     input logic [1:0] e, input logic rdy, c);
    bit was_empty, took, popped;
    cyc++;
    if (r) begin
      q.delete();
      m_ovr    = 0;
      last_act = cyc;
      return;
    end
    was_empty = (q.size() == 0);
    popped    = !was_empty && rdy;
    took      = v && (q.size() < DEPTH || popped);
    if (popped) void'(q.pop_front());
    if (took) q.push_back({e, d});
    if (c) m_ovr = 0;
    if (v && !took) m_ovr = 1;
    if (took || popped || was_empty) last_act = cyc;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void compare_model();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'd0;
    chk("count",   32'(count),   32'(q.size()));
    chk("empty",   32'(empty),   32'(q.size() == 0));
    chk("full",    32'(full),    32'(q.size() == DEPTH));
    chk("afull",   32'(afull),   32'(q.size() >= AFULL));
    chk("valid",   32'(valid),   32'(q.size() > 0));
    chk("dout",    32'(dout),    32'(h[7:0]));
    chk("err",     32'(err),     32'(h[9:8]));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout", 32'(timeout), 32'(q.size() > 0 && (cyc - last_act) >= TO));
  endfunction

  task automatic cycle(input logic r, v, input logic [7:0] d, input logic [1:0] e,
                       input logic rdy, c);
    rst = r; rx_valid = v; rx_data = d; rx_err = e; ready = rdy; clr = c;
    @(posedge clk);
    model_step(r, v, d, e, rdy, c);
    #1;
    rst = 0; rx_valid = 0; ready = 0; clr = 0;
    compare_model();
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] e);
    cycle(1'b0, 1'b1, d, e, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       r, v;
    logic [7:0] d;
    logic [1:0] e;
    logic       rdy, c;
    int         cnt;
    logic       vld;
    logic [7:0] dout;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    cyc = 0; last_act = 0; m_ovr = 0;

    // Directed table: single push/pop, FWFT latency, error tag pairing.
    vecs.push_back('{1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 2'b00});
    vecs.push_back('{0, 1, 8'hA6, 2'b00, 0, 0, 1, 1, 8'hA6, 2'b00});
    vecs.push_back('{0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00});
    vecs.push_back('{0, 1, 8'h37, 2'b01, 0, 0, 1, 1, 8'h37, 2'b01});
    vecs.push_back('{0, 1, 8'hFF, 2'b10, 0, 0, 2, 1, 8'h37, 2'b01});
    vecs.push_back('{0, 0, 8'h00, 2'b00, 1, 0, 1, 1, 8'hFF, 2'b10});
    vecs.push_back('{0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00});
    vecs.push_back('{0, 1, 8'h5A, 2'b11, 1, 0, 1, 1, 8'h5A, 2'b11});
    vecs.push_back('{0, 1, 8'h11, 2'b00, 1, 0, 1, 1, 8'h11, 2'b00});
    vecs.push_back('{0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00});
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].rdy, vecs[i].c);
      chk("tbl_count", 32'(count), 32'(vecs[i].cnt));
      chk("tbl_valid", 32'(valid), 32'(vecs[i].vld));
      chk("tbl_dout",  32'(dout),  32'(vecs[i].dout));
      chk("tbl_err",   32'(err),   32'(vecs[i].err));
    end

    // Fill to full, drop one, drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 2'b00);
      chk("fill_afull", 32'(afull), 32'(i + 1 >= 12));
      chk("fill_full",  32'(full),  32'(i + 1 == 16));
    end
    push(8'hFF, 2'b11);
    chk("drop_ovr",   32'(overrun), 32'd1);
    chk("drop_count", 32'(count),   32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", 32'(dout), 32'(i));
      cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i), 2'b00);
    cycle(1'b0, 1'b1, 8'h55, 2'b00, 1'b1, 1'b0);
    chk("pp_full_ovr",   32'(overrun), 32'd0);
    chk("pp_full_count", 32'(count),   32'd16);
    for (int i = 1; i < 16; i++) begin
      chk("pp_drain", 32'(dout), 32'(i));
      cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    end
    chk("pp_last", 32'(dout), 32'h55);
    cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

    // Character timeout: exact rise, re-arm on push, stays low once empty.
    do_reset();
    push(8'hC3, 2'b00);
    for (int i = 1; i < 64; i++) idle_cycle();
    chk("to_before", 32'(timeout), 32'd0);
    idle_cycle();
    chk("to_rise", 32'(timeout), 32'd1);
    push(8'h3C, 2'b00);
    chk("to_clear", 32'(timeout), 32'd0);
    for (int i = 1; i < 64; i++) idle_cycle();
    chk("to_before2", 32'(timeout), 32'd0);
    idle_cycle();
    chk("to_rise2", 32'(timeout), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) idle_cycle();
    chk("to_empty", 32'(timeout), 32'd0);

    // Reset with 5 entries and overrun pending; then drop coinciding with clear.
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i + 8'h40), 2'b01);
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count),   32'd5);
    chk("pre_rst_ovr",   32'(overrun), 32'd1);
    do_reset();
    chk("rst_count", 32'(count),   32'd0);
    chk("rst_empty", 32'(empty),   32'd1);
    chk("rst_ovr",   32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(i), 2'b00);
    cycle(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0, 1'b1);
    chk("drop_clr_ovr", 32'(overrun), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    chk("clr_ovr", 32'(overrun), 32'd0);

    // Random traffic with shifting producer/consumer rates.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int unsigned vpct, rpct;
      case ((i / 400) % 5)
        0: begin vpct = 70; rpct = 20; end
        1: begin vpct = 30; rpct = 80; end
        2: begin vpct = 2;  rpct = 0;  end
        3: begin vpct = 50; rpct = 50; end
        default: begin vpct = 90; rpct = 5; end
      endcase
      cycle($urandom_range(0, 999) < 2,
            $urandom_range(0, 99) < vpct,
            8'($urandom), 2'($urandom),
            $urandom_range(0, 99) < rpct,
            $urandom_range(0, 99) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
